// File: rtl/gray_histogram_stat.sv
// Per-frame 256-bin gray-level histogram: pipelined read-modify-write accumulation,
// then a valid/ready readout that clears each bin as it is accepted.
module gray_histogram_stat #(
    parameter int unsigned IMG_HDISP = 512,
    parameter int unsigned IMG_VDISP = 512,
    parameter int unsigned CNT_WIDTH = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 per_img_vsync,
    input  logic                 per_img_href,
    input  logic [7:0]           per_img_gray,
    output logic                 hist_vld,
    input  logic                 hist_rdy,
    output logic [7:0]           hist_bin,
    output logic [CNT_WIDTH-1:0] hist_cnt,
    output logic                 hist_last,
    output logic                 busy,
    output logic                 frame_drop
);

    localparam int unsigned BIN_W     = 8;
    localparam int unsigned NUM_BINS  = 1 << BIN_W;
    localparam int unsigned FRAME_PIX = IMG_HDISP * IMG_VDISP;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [BIN_W-1:0]     LAST_BIN = BIN_W'(NUM_BINS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_READ
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 vsync_d;
    logic [BIN_W-1:0]     clr_ptr;
    logic [BIN_W-1:0]     rd_ptr;
    logic                 flush_cnt;

    logic                 p1_vld;
    logic [BIN_W-1:0]     p1_addr;
    logic                 p2_vld;
    logic [BIN_W-1:0]     p2_addr;
    logic [CNT_WIDTH-1:0] p2_data;
    logic                 p3_vld;
    logic [BIN_W-1:0]     p3_addr;
    logic [CNT_WIDTH-1:0] p3_data;

    logic [CNT_WIDTH-1:0] mem [NUM_BINS];
    logic [CNT_WIDTH-1:0] rd_q;

    logic                 rise_c;
    logic                 pix_c;
    logic                 accept_c;
    logic                 load_c;
    logic                 rd_en_c;
    logic [BIN_W-1:0]     rd_addr_c;
    logic                 we_c;
    logic [BIN_W-1:0]     wr_addr_c;
    logic [CNT_WIDTH-1:0] wr_data_c;
    logic [CNT_WIDTH-1:0] base_c;
    logic [CNT_WIDTH-1:0] sum_c;
    logic                 unused_frame_pix;

    // Frame geometry only bounds the count width; it does not drive any logic.
    assign unused_frame_pix = (FRAME_PIX == 0);

    assign hist_cnt = rd_q;

    // Control strobes: frame edge, countable pixel, readout handshake and fetch.
    always_comb begin
        rise_c   = per_img_vsync & ~vsync_d;
        pix_c    = per_img_vsync & per_img_href &
                   ((state == S_ACCUM) | ((state == S_IDLE) & rise_c));
        accept_c = hist_vld & hist_rdy;
        load_c   = (state == S_READ) & (~hist_vld | (hist_rdy & ~hist_last));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_ptr == LAST_BIN)      state_nxt = S_IDLE;
            S_IDLE:  if (rise_c)                   state_nxt = S_ACCUM;
            S_ACCUM: if (!per_img_vsync)           state_nxt = S_FLUSH;
            S_FLUSH: if (flush_cnt)                state_nxt = S_READ;
            S_READ:  if (accept_c && hist_last)    state_nxt = S_IDLE;
            default:                               state_nxt = S_CLEAR;
        endcase
    end

    // Forward the two in-flight writes so back-to-back equal bins count exactly.
    always_comb begin
        base_c = rd_q;
        if (p2_vld && (p2_addr == p1_addr)) begin
            base_c = p2_data;
        end else if (p3_vld && (p3_addr == p1_addr)) begin
            base_c = p3_data;
        end
        sum_c = (base_c == CNT_MAX) ? CNT_MAX : base_c + CNT_WIDTH'(1);
    end

    // Shared RAM ports: one read, one write, muxed by operating phase.
    always_comb begin
        rd_en_c   = pix_c | load_c;
        rd_addr_c = load_c ? rd_ptr : per_img_gray;
        we_c      = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        if (state == S_CLEAR) begin
            we_c      = 1'b1;
            wr_addr_c = clr_ptr;
        end else if (p2_vld) begin
            we_c      = 1'b1;
            wr_addr_c = p2_addr;
            wr_data_c = p2_data;
        end else if ((state == S_READ) && accept_c) begin
            we_c      = 1'b1;
            wr_addr_c = hist_bin;
        end
        if (rst) begin
            we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    // Synchronous read register; doubles as the readout count holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_en_c) begin
            rd_q <= mem[rd_addr_c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            vsync_d    <= 1'b0;
            clr_ptr    <= '0;
            rd_ptr     <= '0;
            flush_cnt  <= 1'b0;
            p1_vld     <= 1'b0;
            p1_addr    <= '0;
            p2_vld     <= 1'b0;
            p2_addr    <= '0;
            p2_data    <= '0;
            p3_vld     <= 1'b0;
            p3_addr    <= '0;
            p3_data    <= '0;
            hist_vld   <= 1'b0;
            hist_bin   <= '0;
            hist_last  <= 1'b0;
            busy       <= 1'b1;
            frame_drop <= 1'b0;
        end else begin
            state     <= state_nxt;
            vsync_d   <= per_img_vsync;
            clr_ptr   <= (state == S_CLEAR) ? clr_ptr + BIN_W'(1) : '0;
            flush_cnt <= (state == S_FLUSH);

            p1_vld  <= pix_c;
            p1_addr <= per_img_gray;
            p2_vld  <= p1_vld;
            p2_addr <= p1_addr;
            p2_data <= sum_c;
            p3_vld  <= p2_vld;
            p3_addr <= p2_addr;
            p3_data <= p2_data;

            if (state != S_READ) begin
                rd_ptr <= '0;
            end else if (load_c) begin
                rd_ptr <= rd_ptr + BIN_W'(1);
            end

            if (load_c) begin
                hist_vld  <= 1'b1;
                hist_bin  <= rd_ptr;
                hist_last <= (rd_ptr == LAST_BIN);
            end else if (accept_c) begin
                hist_vld  <= 1'b0;
                hist_last <= 1'b0;
            end

            busy       <= (state_nxt != S_IDLE);
            frame_drop <= rise_c & ((state == S_CLEAR) | (state == S_FLUSH) | (state == S_READ));
        end
    end

endmodule

// File: tb/tb_gray_histogram_stat.sv
// Scoreboard bench: a wide and a 4-bit-count instance share one pixel stream; a frame-level
// histogram model queues the expected readout and a negedge monitor checks every valid cycle.
module tb_gray_histogram_stat;

    localparam int MAIN_W    = 19;
    localparam int SMALL_W   = 4;
    localparam int MAIN_MAX  = (1 << MAIN_W) - 1;
    localparam int SMALL_MAX = (1 << SMALL_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               per_img_vsync = 1'b0;
    logic               per_img_href = 1'b0;
    logic [7:0]         per_img_gray = 8'd0;
    logic               hist_rdy = 1'b1;

    logic               hist_vld, hist_last, busy, frame_drop;
    logic [7:0]         hist_bin;
    logic [MAIN_W-1:0]  hist_cnt;
    logic               s_hist_vld, s_hist_last, s_busy, s_frame_drop;
    logic [7:0]         s_hist_bin;
    logic [SMALL_W-1:0] s_hist_cnt;

    typedef struct {
        int bin;
        int cnt;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    model_hist[256];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    exp_vld_cyc = -1;
    int    exp_drop_cyc = -1;
    int    exp_drops = 0;
    int    drops_seen = 0;
    bit    mon_en = 1'b0;
    bit    rdy_rand = 1'b0;
    bit    prev_vld = 1'b0;

    gray_histogram_stat #(.CNT_WIDTH(MAIN_W)) u_main (
        .clk(clk), .rst(rst),
        .per_img_vsync(per_img_vsync), .per_img_href(per_img_href), .per_img_gray(per_img_gray),
        .hist_vld(hist_vld), .hist_rdy(hist_rdy), .hist_bin(hist_bin), .hist_cnt(hist_cnt),
        .hist_last(hist_last), .busy(busy), .frame_drop(frame_drop)
    );

    gray_histogram_stat #(.CNT_WIDTH(SMALL_W)) u_small (
        .clk(clk), .rst(rst),
        .per_img_vsync(per_img_vsync), .per_img_href(per_img_href), .per_img_gray(per_img_gray),
        .hist_vld(s_hist_vld), .hist_rdy(hist_rdy), .hist_bin(s_hist_bin), .hist_cnt(s_hist_cnt),
        .hist_last(s_hist_last), .busy(s_busy), .frame_drop(s_frame_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int pix_value(input int kind, input int c);
        case (kind)
            0:       return 128;
            1:       return c % 256;
            2:       return ((c % 8) == 4 || (c % 8) == 6) ? 7 : 5;
            3:       return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                                                        : int'($urandom_range(60, 62));
            default: return 9;
        endcase
    endfunction

    // Monitor: compare every valid cycle against the queue head, pop on handshake.
    always @(negedge clk) begin : monitor
        beat_t e;
        bit    r;
        if (mon_en) begin
            if (hist_vld || s_hist_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat cyc=%0d vld=%0d bin=%0d", cyc, hist_vld, hist_bin);
                end else begin
                    e = exp_q[0];
                    if (!hist_vld || hist_bin != 8'(e.bin) || hist_cnt != MAIN_W'(sat(e.cnt, MAIN_MAX))
                        || hist_last != e.last) begin
                        failures++;
                        $display("FAIL beat_main vld=%0d bin=%0d cnt=%0d last=%0d required bin=%0d cnt=%0d last=%0d",
                                 hist_vld, hist_bin, hist_cnt, hist_last, e.bin, sat(e.cnt, MAIN_MAX), e.last);
                    end
                    checks++;
                    if (!s_hist_vld || s_hist_bin != 8'(e.bin) || s_hist_cnt != SMALL_W'(sat(e.cnt, SMALL_MAX))
                        || s_hist_last != e.last) begin
                        failures++;
                        $display("FAIL beat_small vld=%0d bin=%0d cnt=%0d last=%0d required bin=%0d cnt=%0d last=%0d",
                                 s_hist_vld, s_hist_bin, s_hist_cnt, s_hist_last, e.bin, sat(e.cnt, SMALL_MAX), e.last);
                    end
                end
            end
            if (hist_vld && !prev_vld) begin
                checks++;
                if (cyc != exp_vld_cyc) begin
                    failures++;
                    $display("FAIL first_vld_latency cyc=%0d required=%0d", cyc, exp_vld_cyc);
                end
            end
            prev_vld = hist_vld;
            if (frame_drop || s_frame_drop) begin
                checks++;
                drops_seen++;
                if (!(frame_drop && s_frame_drop) || cyc != exp_drop_cyc) begin
                    failures++;
                    $display("FAIL frame_drop main=%0d small=%0d cyc=%0d required_cyc=%0d",
                             frame_drop, s_frame_drop, cyc, exp_drop_cyc);
                end
            end
            r = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            hist_rdy = r;
            if (hist_vld && r && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, req);
        end
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int b = 0; b < 256; b++) model_hist[b] = 0;
        exp_vld_cyc = -1;
        check_bit("reset_vld", hist_vld, 1'b0);
        check_bit("reset_last", hist_last, 1'b0);
        check_bit("reset_drop", frame_drop, 1'b0);
        check_bit("reset_busy", busy, 1'b1);
        check_bit("reset_small_vld", s_hist_vld, 1'b0);
        checks++;
        if (hist_bin !== 8'd0 || hist_cnt !== '0 || s_hist_cnt !== '0) begin
            failures++;
            $display("FAIL reset_bin_cnt bin=%0d cnt=%0d small_cnt=%0d required 0", hist_bin, hist_cnt, s_hist_cnt);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 1000);
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL busy_after_reset cycles=%0d required=256", n);
        end
        check_bit("small_busy_after_reset", s_busy, 1'b0);
    endtask

    // Drive one frame; accepted frames feed the model and queue their 256-beat readout.
    task automatic drive_frame(input int kind, input int w, input int h, input bit accept);
        int g;
        @(negedge clk);
        if (!accept) begin
            exp_drops++;
            exp_drop_cyc = cyc + 1;
        end
        per_img_vsync = 1'b1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                g = pix_value(kind, c);
                per_img_href = 1'b1;
                per_img_gray = 8'(g);
                if (accept) model_hist[g]++;
                @(negedge clk);
            end
            if (r != h - 1) begin
                per_img_href = 1'b0;
                per_img_gray = 8'($urandom);
                repeat (2) @(negedge clk);
            end
        end
        per_img_vsync = 1'b0;
        if (accept) begin
            exp_vld_cyc = cyc + 4;
            for (int b = 0; b < 256; b++) begin
                exp_q.push_back('{bin: b, cnt: model_hist[b], last: (b == 255)});
                model_hist[b] = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            per_img_href = 1'b1;
            per_img_gray = 8'($urandom);
            @(negedge clk);
        end
        per_img_href = 1'b0;
    endtask

    task automatic wait_q_le(input int k);
        int n = 0;
        while (exp_q.size() > k && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        checks++;
        if (hist_vld || s_hist_vld || busy || s_busy) begin
            failures++;
            $display("FAIL end_of_readout vld=%0d busy=%0d small_vld=%0d small_busy=%0d required all 0",
                     hist_vld, busy, s_hist_vld, s_busy);
        end
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;

        drive_frame(0, 64, 16, 1'b1);
        wait_drain();
        drive_frame(1, 256, 4, 1'b1);
        wait_drain();
        drive_frame(2, 8, 4, 1'b1);
        wait_drain();

        rdy_rand = 1'b1;
        drive_frame(1, 256, 4, 1'b1);
        wait_drain();
        rdy_rand = 1'b0;
        drive_frame(1, 256, 4, 1'b1);
        wait_drain();

        drive_frame(4, 20, 1, 1'b1);
        wait_drain();

        drive_frame(0, 64, 16, 1'b1);
        wait_q_le(246);
        drive_frame(3, 40, 8, 1'b0);
        wait_drain();
        rdy_rand = 1'b1;
        drive_frame(3, 64, 8, 1'b1);
        wait_drain();
        rdy_rand = 1'b0;

        drive_frame(0, 64, 16, 1'b1);
        wait_q_le(156);
        do_reset();
        drive_frame(0, 64, 16, 1'b1);
        wait_drain();

        rdy_rand = 1'b1;
        drive_frame(3, 96, 6, 1'b1);
        wait_drain();

        checks++;
        if (drops_seen != exp_drops) begin
            failures++;
            $display("FAIL drop_count actual=%0d required=%0d", drops_seen, exp_drops);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
